// File: rtl/pipe_ctrl.sv
// Pipeline hazard and stall controller: load-use bubbles, branch flushes,
// data-memory wait handling with a sticky timeout error, and event counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [4:0]  id_rs_top,
  input  logic [4:0]  id_rs_bot,
  input  logic [1:0]  id_rs_used,
  input  logic [4:0]  ex_rd_top,
  input  logic [4:0]  ex_rd_bot,
  input  logic [1:0]  ex_wen,
  input  logic        ex_is_load,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [1:0]  state,
  output logic        err_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_r;
  state_t      state_view_s;
  logic [7:0]  wait_cnt_r;
  logic        err_timeout_r;
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;
  logic        load_use_s;
  logic        branch_flush_s;

  // Register 0 is compared like any other address; it is not hardwired to zero here.
  function automatic logic addr_match(input logic [4:0] addr, input logic [1:0] wen,
                                      input logic [4:0] rd_top, input logic [4:0] rd_bot);
    return (wen[1] && (addr == rd_top)) || (wen[0] && (addr == rd_bot));
  endfunction

  assign load_use_s = ex_is_load &
                      ((id_rs_used[1] & addr_match(id_rs_top, ex_wen, ex_rd_top, ex_rd_bot)) |
                       (id_rs_used[0] & addr_match(id_rs_bot, ex_wen, ex_rd_top, ex_rd_bot)));

  // While nreset is low the outputs behave as if already back in RUN.
  always_comb begin
    if (!nreset) begin
      state_view_s = RUN;
    end else begin
      state_view_s = state_r;
    end
  end

  assign branch_flush_s = (state_view_s != ERR) & ~mem_busy & branch_taken;

  // Stall/flush decode: ERR and memory wait freeze everything, branch beats load-use.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    if ((state_view_s == ERR) || mem_busy) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (branch_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use_s) begin
      stall_if = 1'b1;
      flush_ex = 1'b1;
    end else begin
      flush_ex = 1'b0;
    end
  end

  // Control FSM with memory wait counter; ERR is left only through reset.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_r       <= RUN;
      wait_cnt_r    <= 8'd0;
      err_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        RUN, MEM_WAIT: begin
          if (mem_busy) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
            if (wait_cnt_r == WAIT_LAST) begin
              state_r       <= ERR;
              err_timeout_r <= 1'b1;
            end else begin
              state_r <= MEM_WAIT;
            end
          end else begin
            state_r    <= RUN;
            wait_cnt_r <= 8'd0;
          end
        end
        ERR: begin
          if (!mem_busy) begin
            wait_cnt_r <= 8'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        default: begin
          state_r <= ERR;
        end
      endcase
    end
  end

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (stall_if && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
      if (branch_flush_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end

  assign state       = state_r;
  assign err_timeout = err_timeout_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        nreset;
  logic [4:0]  id_rs_top, id_rs_bot, ex_rd_top, ex_rd_bot;
  logic [1:0]  id_rs_used, ex_wen, state;
  logic        ex_is_load, branch_taken, mem_busy;
  logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, err_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clock(clock), .nreset(nreset),
    .id_rs_top(id_rs_top), .id_rs_bot(id_rs_bot), .id_rs_used(id_rs_used),
    .ex_rd_top(ex_rd_top), .ex_rd_bot(ex_rd_bot), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .state(state), .err_timeout(err_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input string field, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h exp=%h", name, field, got, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp(e.name, "ctl", {10'd0, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex},
          {10'd0, e.ctl});
      cmp(e.name, "state", {14'd0, state}, {14'd0, e.st});
      cmp(e.name, "err", {15'd0, err_timeout}, {15'd0, e.err});
      cmp(e.name, "stall_cnt", stall_cnt, e.sc);
      cmp(e.name, "flush_cnt", flush_cnt, e.fc);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic chk(input string name, input logic [5:0] ctl, input logic [1:0] st,
                     input logic err, input logic [15:0] sc, input logic [15:0] fc);
    sb_q.push_back('{name, ctl, st, err, sc, fc});
    step();
  endtask

  task automatic set_idle();
    id_rs_top = 5'd0; id_rs_bot = 5'd0; id_rs_used = 2'b00;
    ex_rd_top = 5'd0; ex_rd_bot = 5'd0; ex_wen = 2'b00;
    ex_is_load = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_lu();
    ex_is_load = 1'b1; ex_wen = 2'b10; ex_rd_top = 5'd5; id_rs_top = 5'd5; id_rs_used = 2'b10;
  endtask

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b100001;
  localparam logic [5:0] C_BR    = 6'b000011;
  localparam logic [5:0] C_STALL = 6'b111100;

  initial begin
    set_idle();
    nreset = 1'b0;
    step();
    chk("reset", C_NONE, 2'd0, 1'b0, 16'd0, 16'd0);
    nreset = 1'b1;

    set_lu();
    chk("lu", C_LU, 2'd0, 1'b0, 16'd0, 16'd0);
    set_idle();
    chk("lu_clear", C_NONE, 2'd0, 1'b0, 16'd1, 16'd0);

    ex_is_load = 1'b1; ex_wen = 2'b01; ex_rd_bot = 5'd0; id_rs_bot = 5'd0; id_rs_used = 2'b01;
    chk("lu_r0", C_LU, 2'd0, 1'b0, 16'd1, 16'd0);
    ex_rd_bot = 5'd4; id_rs_bot = 5'd3;
    chk("no_match", C_NONE, 2'd0, 1'b0, 16'd2, 16'd0);
    ex_rd_bot = 5'd3; ex_wen = 2'b00;
    chk("no_wen", C_NONE, 2'd0, 1'b0, 16'd2, 16'd0);
    ex_wen = 2'b01; id_rs_used = 2'b00;
    chk("no_used", C_NONE, 2'd0, 1'b0, 16'd2, 16'd0);
    id_rs_used = 2'b01; ex_is_load = 1'b0;
    chk("no_load", C_NONE, 2'd0, 1'b0, 16'd2, 16'd0);

    set_idle(); set_lu(); branch_taken = 1'b1;
    chk("branch", C_BR, 2'd0, 1'b0, 16'd2, 16'd0);
    set_idle();
    chk("branch_clear", C_NONE, 2'd0, 1'b0, 16'd2, 16'd1);

    set_lu(); branch_taken = 1'b1; mem_busy = 1'b1;
    chk("memwait1", C_STALL, 2'd0, 1'b0, 16'd2, 16'd1);
    chk("memwait2", C_STALL, 2'd1, 1'b0, 16'd3, 16'd1);
    chk("memwait3", C_STALL, 2'd1, 1'b0, 16'd4, 16'd1);
    set_idle();
    chk("memwait_rel", C_NONE, 2'd1, 1'b0, 16'd5, 16'd1);
    chk("memwait_run", C_NONE, 2'd0, 1'b0, 16'd5, 16'd1);

    mem_busy = 1'b1;
    chk("midwait1", C_STALL, 2'd0, 1'b0, 16'd5, 16'd1);
    chk("midwait2", C_STALL, 2'd1, 1'b0, 16'd6, 16'd1);
    nreset = 1'b0;
    chk("midwait_rst", C_STALL, 2'd1, 1'b0, 16'd7, 16'd1);
    nreset = 1'b1; mem_busy = 1'b0;
    chk("midwait_after", C_NONE, 2'd0, 1'b0, 16'd0, 16'd0);

    mem_busy = 1'b1;
    chk("tmo1", C_STALL, 2'd0, 1'b0, 16'd0, 16'd0);
    chk("tmo2", C_STALL, 2'd1, 1'b0, 16'd1, 16'd0);
    chk("tmo3", C_STALL, 2'd1, 1'b0, 16'd2, 16'd0);
    chk("tmo4", C_STALL, 2'd1, 1'b0, 16'd3, 16'd0);
    mem_busy = 1'b0;
    chk("err_hold", C_STALL, 2'd2, 1'b1, 16'd4, 16'd0);
    set_lu(); branch_taken = 1'b1;
    chk("err_branch", C_STALL, 2'd2, 1'b1, 16'd5, 16'd0);
    nreset = 1'b0;
    chk("err_rst", C_BR, 2'd2, 1'b1, 16'd6, 16'd0);
    nreset = 1'b1; set_idle();
    chk("err_cleared", C_NONE, 2'd0, 1'b0, 16'd0, 16'd0);

    set_lu();
    for (int i = 0; i < 65534; i++) step();
    chk("sat_fffe", C_LU, 2'd0, 1'b0, 16'hFFFE, 16'd0);
    chk("sat_ffff", C_LU, 2'd0, 1'b0, 16'hFFFF, 16'd0);
    for (int i = 0; i < 4464; i++) step();
    chk("sat_hold", C_LU, 2'd0, 1'b0, 16'hFFFF, 16'd0);
    set_idle();
    chk("sat_idle", C_NONE, 2'd0, 1'b0, 16'hFFFF, 16'd0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
